// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: per-ghost NORM/FRGT/SCOR/DEAD sequencing with a shared frightened timer,
// score-display freeze, flash and frill-animation dividers.
module ghost_mode_ctrl #(
    parameter int FRGT_FRAMES  = 360,
    parameter int FLASH_START  = 120,
    parameter int FLASH_PERIOD = 12,
    parameter int SCORE_FRAMES = 60,
    parameter int ANIM_PERIOD  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       power_pellet,
    input  logic [3:0] ghost_eaten,
    input  logic [3:0] ghost_home,
    output logic [7:0] ghost_mode,
    output logic       ghost_flash,
    output logic       animation_cycle,
    output logic [1:0] score_idx,
    output logic       freeze
);
    localparam logic [1:0] NORM = 2'd0, FRGT = 2'd1, SCOR = 2'd2, DEAD = 2'd3;
    localparam logic [9:0] FRGT_LD    = 10'(FRGT_FRAMES);
    localparam logic [9:0] FLASH_TH   = 10'(FLASH_START);
    localparam logic [9:0] FLASH_LAST = 10'(FLASH_PERIOD - 1);
    localparam logic [9:0] SCORE_LD   = 10'(SCORE_FRAMES);
    localparam logic [9:0] ANIM_LAST  = 10'(ANIM_PERIOD - 1);

    logic [7:0] r_mode, w_mode_nxt;
    logic [9:0] r_fcnt, r_stmr, r_fdiv, r_adiv, w_fcnt_nxt;
    logic       r_flash, r_anim, r_freeze;
    logic [1:0] r_score, r_next_idx;
    logic [3:0] w_frgt, w_elig, w_pick;
    logic       w_fdec, w_expire, w_sdone, w_eat_ok, w_eat, w_freeze_nxt;

    // The frightened timer only runs while gameplay is not frozen; its 1->0 step is the expiry.
    always_comb begin
        w_fdec     = frame_tick && !r_freeze && (r_fcnt != 10'd0) && !power_pellet;
        w_expire   = w_fdec && (r_fcnt == 10'd1);
        w_sdone    = frame_tick && (r_stmr == 10'd1);
        w_eat_ok   = !r_freeze && !power_pellet && !w_expire;
        w_fcnt_nxt = power_pellet ? FRGT_LD : w_fdec ? r_fcnt - 10'd1 : r_fcnt;
        for (int i = 0; i < 4; i++) w_frgt[i] = (r_mode[2*i+:2] == FRGT);
        w_elig = ghost_eaten & w_frgt & {4{w_eat_ok}};
        w_pick = w_elig & (~w_elig + 4'd1);
        w_eat  = |w_pick;
    end

    always_comb begin
        w_mode_nxt   = r_mode;
        w_freeze_nxt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_mode_nxt[2*i+:2] =
                (r_mode[2*i+:2] == NORM) ? (power_pellet ? FRGT : NORM) :
                (r_mode[2*i+:2] == FRGT) ? (w_pick[i] ? SCOR : w_expire ? NORM : FRGT) :
                (r_mode[2*i+:2] == SCOR) ? (w_sdone ? DEAD : SCOR) :
                (ghost_home[i] ? NORM : DEAD);
            w_freeze_nxt = w_freeze_nxt | (w_mode_nxt[2*i+:2] == SCOR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= 8'h00;
            r_freeze <= 1'b0;
        end else begin
            r_mode   <= w_mode_nxt;
            r_freeze <= w_freeze_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt     <= '0;
            r_stmr     <= '0;
            r_score    <= '0;
            r_next_idx <= '0;
        end else begin
            r_fcnt <= w_fcnt_nxt;
            r_stmr <= w_eat ? SCORE_LD : (frame_tick && r_stmr != 10'd0) ? r_stmr - 10'd1 : r_stmr;
            if (power_pellet) begin
                r_score    <= '0;
                r_next_idx <= '0;
            end else if (w_eat) begin
                r_score    <= r_next_idx;
                r_next_idx <= (r_next_idx == 2'd3) ? 2'd3 : r_next_idx + 2'd1;
            end
        end
    end

    // Flash phase restarts at 0 whenever the timer enters the flash window from above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fdiv  <= '0;
            r_flash <= 1'b0;
            r_adiv  <= '0;
            r_anim  <= 1'b0;
        end else begin
            if (power_pellet || w_fcnt_nxt == 10'd0 || w_fcnt_nxt > FLASH_TH) begin
                r_fdiv  <= '0;
                r_flash <= 1'b0;
            end else if (w_fdec && r_fcnt <= FLASH_TH) begin
                r_fdiv  <= (r_fdiv == FLASH_LAST) ? 10'd0 : r_fdiv + 10'd1;
                r_flash <= r_flash ^ (r_fdiv == FLASH_LAST);
            end
            if (frame_tick) begin
                r_adiv <= (r_adiv == ANIM_LAST) ? 10'd0 : r_adiv + 10'd1;
                r_anim <= r_anim ^ (r_adiv == ANIM_LAST);
            end
        end
    end

    always_comb begin
        ghost_mode      = r_mode;
        ghost_flash     = r_flash;
        animation_cycle = r_anim;
        score_idx       = r_score;
        freeze          = r_freeze;
    end
endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// tb_ghost_mode_ctrl: directed scenarios plus random traffic against a frame-level reference model.
module tb_ghost_mode_ctrl;
    localparam int FF = 20, FS = 8, FP = 2, SF = 3, AP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, power_pellet = 1'b0;
    logic [3:0] ghost_eaten = '0, ghost_home = '0;
    logic [7:0] ghost_mode;
    logic       ghost_flash, animation_cycle, freeze;
    logic [1:0] score_idx;

    int n_cmp = 0, n_err = 0;

    // reference state: ghost modes as ints (0 NORM,1 FRGT,2 SCOR,3 DEAD)
    int m[4];
    int fcnt, stmr, ticks, score, eats;

    ghost_mode_ctrl #(.FRGT_FRAMES(FF), .FLASH_START(FS), .FLASH_PERIOD(FP),
                      .SCORE_FRAMES(SF), .ANIM_PERIOD(AP)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .power_pellet(power_pellet),
        .ghost_eaten(ghost_eaten), .ghost_home(ghost_home), .ghost_mode(ghost_mode),
        .ghost_flash(ghost_flash), .animation_cycle(animation_cycle),
        .score_idx(score_idx), .freeze(freeze));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = 0;
        fcnt = 0; stmr = 0; ticks = 0; score = 0; eats = 0;
    endtask

    function automatic bit any_scor();
        for (int i = 0; i < 4; i++) if (m[i] == 2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit pp, input logic [3:0] ev, input logic [3:0] hv, input bit tk);
        bit frozen, dec, expire, sdone;
        int eat;
        frozen = any_scor();
        dec    = tk && !frozen && fcnt > 0 && !pp;
        expire = dec && fcnt == 1;
        sdone  = tk && stmr == 1;
        eat    = -1;
        if (!frozen && !pp && !expire)
            for (int i = 3; i >= 0; i--) if (ev[i] && m[i] == 1) eat = i;
        for (int i = 0; i < 4; i++) begin
            if (m[i] == 0 && pp) m[i] = 1;
            else if (m[i] == 1 && i == eat) m[i] = 2;
            else if (m[i] == 1 && expire) m[i] = 0;
            else if (m[i] == 2 && sdone) m[i] = 3;
            else if (m[i] == 3 && hv[i]) m[i] = 0;
        end
        fcnt = pp ? FF : dec ? fcnt - 1 : fcnt;
        stmr = (eat >= 0) ? SF : (tk && stmr > 0) ? stmr - 1 : stmr;
        if (pp) begin
            score = 0; eats = 0;
        end else if (eat >= 0) begin
            score = (eats > 3) ? 3 : eats;
            eats++;
        end
        if (tk) ticks++;
    endtask

    task automatic check_all();
        logic [7:0] em;
        int fl;
        for (int i = 0; i < 4; i++) em[2*i+:2] = 2'(m[i]);
        // flash phase depends only on how far the timer has fallen into the window
        fl = (fcnt > 0 && fcnt <= FS) ? ((FS - fcnt) / FP) % 2 : 0;
        chk("ghost_mode", ghost_mode, em);
        chk("ghost_flash", ghost_flash, 32'(fl));
        chk("animation_cycle", animation_cycle, 32'((ticks / AP) % 2));
        chk("score_idx", score_idx, 32'(score));
        chk("freeze", freeze, 32'(any_scor()));
    endtask

    task automatic step(input bit pp, input logic [3:0] ev, input logic [3:0] hv, input bit tk);
        power_pellet = pp; ghost_eaten = ev; ghost_home = hv; frame_tick = tk;
        @(posedge clk);
        model_step(pp, ev, hv, tk);
        #1;
        power_pellet = 0; ghost_eaten = '0; ghost_home = '0; frame_tick = 0;
        check_all();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 4'h0, 4'h0, 1);
            step(0, 4'h0, 4'h0, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mode"}, ghost_mode, 8'h00);
        chk({tag, "_flash"}, ghost_flash, 1'b0);
        chk({tag, "_anim"}, animation_cycle, 1'b0);
        chk({tag, "_score"}, score_idx, 2'd0);
        chk({tag, "_freeze"}, freeze, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // full frightened period with flash window
        step(1, 4'h0, 4'h0, 0);
        chk("pellet_mode", ghost_mode, 8'h55);
        frames(FF - 1);
        chk("pre_expiry_mode", ghost_mode, 8'h55);
        frames(1);
        chk("expiry_mode", ghost_mode, 8'h00);
        chk("expiry_flash", ghost_flash, 1'b0);

        // expiry beats an eat on the same edge
        step(1, 4'h0, 4'h0, 0);
        frames(FF - 1);
        step(0, 4'h1, 4'h0, 1);
        chk("expiry_vs_eat_mode", ghost_mode, 8'h00);
        chk("expiry_vs_eat_freeze", freeze, 1'b0);

        // simultaneous eats: lowest index wins
        step(1, 4'h0, 4'h0, 0);
        step(0, 4'b0110, 4'h0, 0);
        chk("dual_eat_mode", ghost_mode, 8'h59);
        chk("dual_eat_freeze", freeze, 1'b1);
        chk("dual_eat_score", score_idx, 2'd0);
        frames(SF);
        chk("score_done_mode", ghost_mode, 8'h5D);
        chk("score_done_freeze", freeze, 1'b0);

        // three more eats, score index saturating at 3
        step(0, 4'b0001, 4'h0, 0);
        chk("eat2_score", score_idx, 2'd1);
        frames(SF);
        step(0, 4'b0100, 4'h0, 0);
        chk("eat3_score", score_idx, 2'd2);
        frames(SF);
        step(0, 4'b1000, 4'h0, 0);
        chk("eat4_score", score_idx, 2'd3);
        frames(SF);
        chk("all_dead", ghost_mode, 8'hFF);

        // dead ghosts ignore the pellet and return to NORM from home
        step(1, 4'h0, 4'h0, 0);
        chk("dead_through_pellet", ghost_mode, 8'hFF);
        chk("pellet_score_reset", score_idx, 2'd0);
        step(0, 4'h0, 4'b0001, 0);
        chk("home_to_norm", ghost_mode, 8'hFC);
        step(0, 4'h0, 4'b1110, 0);
        step(1, 4'h0, 4'h0, 0);
        step(0, 4'b0001, 4'h0, 0);
        chk("fifth_eat_score", score_idx, 2'd0);
        frames(SF);

        // pellet beats a same-cycle eat
        step(1, 4'b1000, 4'h0, 0);
        chk("pellet_vs_eat_mode", ghost_mode, 8'h57);
        chk("pellet_vs_eat_freeze", freeze, 1'b0);
        step(0, 4'h0, 4'b0001, 0);
        frames(FF);
        chk("reload_expiry", ghost_mode, 8'h00);

        // asynchronous reset while frozen
        step(1, 4'h0, 4'h0, 0);
        step(0, 4'b0001, 4'h0, 0);
        chk("pre_reset_freeze", freeze, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        #3 rst_n = 1'b1;
        step(0, 4'h0, 4'h0, 1);

        // random traffic
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 39) == 0,
                 4'($urandom) & 4'($urandom) & 4'($urandom),
                 4'($urandom) & 4'($urandom),
                 $urandom_range(0, 2) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ghost_mode_ctrl.md
GHOST_MODE_CTRL -- requirements
Module: ghost_mode_ctrl

Interface
REQ-001 SHALL have parameter FRGT_FRAMES, default 360: frightened duration in frames (10-bit range, 1..1023).
REQ-002 SHALL have parameter FLASH_START, default 120: remaining-frame count at or below which flashing is enabled.
REQ-003 SHALL have parameter FLASH_PERIOD, default 12: frames per flash half-period.
REQ-004 SHALL have parameter SCORE_FRAMES, default 60: frames a score sprite is shown.
REQ-005 SHALL have parameter ANIM_PERIOD, default 8: frames per frill-animation half-period.
REQ-006 SHALL provide port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL provide port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL provide port frame_tick, input, 1: one-cycle pulse, once per video frame.
REQ-009 SHALL provide port power_pellet, input, 1: one-cycle pulse, power pellet eaten.
REQ-010 SHALL provide port ghost_eaten, input, 4: per-ghost one-cycle pulse, Pac-Man collided with ghost i.
REQ-011 SHALL provide port ghost_home, input, 4: per-ghost level, dead ghost i is in the ghost house.
REQ-012 SHALL provide port ghost_mode, output, 8: ghost i mode in bits [2i+1:2i]; NORM=00, FRGT=01, SCOR=10, DEAD=11.
REQ-013 SHALL provide port ghost_flash, output, 1: shared flash bit for all ghosts.
REQ-014 SHALL provide port animation_cycle, output, 1: frill frame select.
REQ-015 SHALL provide port score_idx, output, 2: score value of the current or last eat (0=200, 1=400, 2=800, 3=1600).
REQ-016 SHALL provide port freeze, output, 1: high while any ghost is in SCOR; gameplay halts.

Function
REQ-017 SHALL register all outputs; an event sampled at edge N SHALL be visible after edge N.
REQ-018 SHALL hold a shared 10-bit frightened counter fcnt; power_pellet SHALL load FRGT_FRAMES.
REQ-019 SHALL decrement fcnt on frame_tick while fcnt>0 and freeze=0; fcnt SHALL hold when freeze=1.
REQ-020 SHALL move each ghost per mode: NORM --power_pellet--> FRGT; FRGT --fcnt reaches 0--> NORM; FRGT --eaten--> SCOR; SCOR --score timer done--> DEAD; DEAD --ghost_home[i]=1--> NORM.
REQ-021 SHALL leave ghosts in DEAD or SCOR unchanged on power_pellet; ghosts in FRGT SHALL stay FRGT with fcnt reloaded.
REQ-022 SHALL ignore ghost_eaten[i] unless ghost i is in FRGT and no ghost is in SCOR.
REQ-023 SHALL, on simultaneous eats, honor only the lowest-index eligible ghost; the others remain FRGT.
REQ-024 SHALL give power_pellet priority over ghost_eaten in the same cycle; that eat is ignored.
REQ-025 SHALL, on the FRGT->NORM expiry cycle, give expiry priority over an eat in the same cycle.
REQ-026 SHALL reset score_idx to 0 on power_pellet.
REQ-027 SHALL latch score_idx on each honored eat and then increment it, saturating at 3. The first eat shows 0 and the fourth and later eats show 3.
REQ-028 SHALL load the score timer with SCORE_FRAMES on an honored eat and decrement it per frame_tick. The ghost SHALL move SCOR->DEAD and freeze SHALL fall on the edge where the timer reaches 0.
REQ-029 SHALL drive ghost_flash=0 when fcnt=0 or fcnt>FLASH_START.
REQ-030 SHALL, at or below FLASH_START, toggle ghost_flash every FLASH_PERIOD frame_ticks, starting from 0 when the threshold is crossed.
REQ-031 SHALL toggle animation_cycle every ANIM_PERIOD frame_ticks regardless of freeze.
REQ-032 SHALL let ghost_home[i] act only while ghost i is in DEAD; it is ignored in all other modes.

Reset
REQ-033 SHALL, with rst_n=0, immediately force: ghost_mode=8'h00, ghost_flash=0, animation_cycle=0, score_idx=0, freeze=0, fcnt=0, score timer=0, all frame dividers=0.
REQ-034 SHALL take effect on reset asserted mid-frightened or mid-score; the first operation after release SHALL be normal.

Verification (bench params FRGT_FRAMES=20, FLASH_START=8, FLASH_PERIOD=2, SCORE_FRAMES=3, ANIM_PERIOD=4)
REQ-035 SHALL cover: power_pellet, then 20 frame_ticks -> ghost_mode=8'h55 until the 20th tick, then 8'h00. ghost_flash is low for 12 ticks, then toggles every 2 ticks, and is 0 at expiry.
REQ-036 SHALL cover: power_pellet, then ghost_eaten=4'b0110 in one cycle -> ghost1=SCOR, ghost2=FRGT, freeze=1, score_idx=0. After 3 ticks ghost1=DEAD, freeze=0, and fcnt is unchanged during the freeze.
REQ-037 SHALL cover: four sequential eats, then a fifth ghost eat after a new pellet -> score_idx 0,1,2,3 across the four eats, then 0 after the pellet.
REQ-038 SHALL cover: ghost0 DEAD, power_pellet, then ghost_home[0]=1 -> ghost0 stays DEAD through the pellet, then becomes NORM (not FRGT).
REQ-039 SHALL cover: power_pellet and ghost_eaten[3] in the same cycle -> ghost3=FRGT, freeze=0, fcnt=20.
REQ-040 SHALL cover: rst_n asserted low while freeze=1 -> all outputs at reset values without waiting for a clk edge.
